// File: rtl/pheap_level.sv
// pheap_level: one level of a pipelined max-heap priority queue (node store, ENQ/DEQ, child forwarding).
// Define PHEAP_REPLACE_EN to add op 3 REPLACE; otherwise op 3 is ignored like NOP.
module pheap_level #(
    parameter int LEVELS = 3,
    parameter int LEVEL  = 1,
    parameter int PW     = 32,
    localparam int AW    = (LEVEL > 1) ? LEVEL - 1 : 1,
    localparam int PAW   = (LEVEL > 2) ? LEVEL - 2 : 1,
    localparam int EW    = PW + LEVELS + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [AW-1:0]    i_addr,
    input  logic [PW-1:0]    i_in_pri,
    output logic             o_ready,
    output logic [1:0]       o_done,
    output logic             o_out_valid,
    output logic [PW-1:0]    o_out_pri,
    output logic [AW-1:0]    o_c_raddr,
    input  logic [EW-1:0]    i_c_rd_l,
    input  logic [EW-1:0]    i_c_rd_r,
    output logic             o_c_start,
    output logic [1:0]       o_c_op,
    output logic [LEVEL-1:0] o_c_addr,
    output logic [PW-1:0]    o_c_pri,
    input  logic [PAW-1:0]   i_p_raddr,
    output logic [EW-1:0]    o_p_rd_l,
    output logic [EW-1:0]    o_p_rd_r
);
    localparam int DEPTH = 2 ** (LEVEL - 1);
    localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);
    localparam logic [LEVELS-1:0] CAP0 = LEVELS'(2 ** (LEVELS - LEVEL + 1) - 1);
    localparam bit LEAF = (LEVEL == LEVELS);
    localparam logic [1:0] ENQ = 2'd1, DEQ = 2'd2;
    localparam logic [1:0] D_DONE = 2'd0, D_WAIT = 2'd1, D_NEXT = 2'd2;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_ptr, r_addr;
    logic [1:0]      r_op;
    logic [PW-1:0]   r_in;
    logic [EW-1:0]   r_mem [DEPTH];

    logic [AW-1:0]     w_idx, w_pl, w_pr, w_widx;
    logic [EW-1:0]     w_node, w_l, w_r, w_wdata;
    logic [PW-1:0]     w_n_pri, w_l_pri, w_r_pri, w_m_pri, w_opri, w_cpri;
    logic [LEVELS-1:0] w_n_cap, w_l_cap, w_r_cap, w_cap_dec, w_cap_inc;
    logic              w_n_act, w_l_act, w_r_act, w_any, w_max_side, w_enq_side, w_in_gt;
    logic              w_enq, w_acc, w_we, w_fwd, w_side, w_oval;
    logic [1:0]        w_cop;

    assign w_idx = r_addr & MASK;
    assign w_node = r_mem[w_idx];
    // A leaf has no children: present them as inactive with zero capacity.
    assign w_l = LEAF ? '0 : i_c_rd_l;
    assign w_r = LEAF ? '0 : i_c_rd_r;
    assign {w_n_pri, w_n_cap, w_n_act} = w_node;
    assign {w_l_pri, w_l_cap, w_l_act} = w_l;
    assign {w_r_pri, w_r_cap, w_r_act} = w_r;
    assign w_any = w_l_act | w_r_act;
    assign w_max_side = w_r_act && (!w_l_act || w_r_pri > w_l_pri);
    assign w_m_pri = w_max_side ? w_r_pri : w_l_pri;
    assign w_enq_side = (w_l_cap == '0) || (w_r_cap > w_l_cap);
    assign w_in_gt = r_in > w_n_pri;
    assign w_cap_dec = (w_n_cap == '0) ? '0 : w_n_cap - LEVELS'(1);
    assign w_cap_inc = (w_n_cap == CAP0) ? CAP0 : w_n_cap + LEVELS'(1);
    assign w_pl = (AW'(i_p_raddr) << 1) & MASK;
    assign w_pr = (w_pl | AW'(1)) & MASK;
    assign o_c_raddr = i_addr;

`ifdef PHEAP_REPLACE_EN
    localparam logic [1:0] REP = 2'd3;
    assign w_enq = r_op == ENQ || (r_op == REP && !w_n_act);
    assign w_acc = i_op != 2'd0;
`else
    assign w_enq = r_op == ENQ;
    assign w_acc = i_op == ENQ || i_op == DEQ;
`endif

    always_comb begin
        w_we = 1'b0;
        w_widx = r_ptr & MASK;
        w_wdata = {{PW{1'b0}}, CAP0, 1'b0};
        w_fwd = 1'b0;
        w_side = 1'b0;
        w_cop = ENQ;
        w_cpri = '0;
        w_oval = 1'b0;
        w_opri = '0;
        if (r_state == S_INIT) begin
            w_we = 1'b1;
        end else if (r_state == S_EXEC) begin
            w_widx = w_idx;
            if (w_enq) begin
                w_we = 1'b1;
                w_oval = w_n_act;
                w_opri = !w_n_act ? '0 : w_in_gt ? w_n_pri : r_in;
                w_wdata = {(w_n_act && !w_in_gt) ? w_n_pri : r_in, w_cap_dec, 1'b1};
                w_cpri = w_opri;
                w_side = w_enq_side;
                w_fwd = w_n_act && !LEAF;
            end else if (w_n_act && r_op == DEQ) begin
                w_we = 1'b1;
                w_oval = 1'b1;
                w_opri = w_n_pri;
                w_wdata = {w_any ? w_m_pri : {PW{1'b0}}, w_cap_inc, w_any};
                w_side = w_max_side;
                w_fwd = w_any;
                w_cop = DEQ;
`ifdef PHEAP_REPLACE_EN
            end else if (w_n_act) begin
                w_we = 1'b1;
                w_oval = 1'b1;
                w_opri = w_n_pri;
                w_fwd = w_any && r_in < w_m_pri;
                w_wdata = {w_fwd ? w_m_pri : r_in, w_n_cap, 1'b1};
                w_side = w_max_side;
                w_cop = REP;
                w_cpri = r_in;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_widx] <= w_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_ptr <= '0;
            r_op <= '0;
            r_addr <= '0;
            r_in <= '0;
            o_ready <= 1'b0;
            o_done <= D_WAIT;
            o_out_valid <= 1'b0;
            o_out_pri <= '0;
            o_c_start <= 1'b0;
            o_c_op <= '0;
            o_c_addr <= '0;
            o_c_pri <= '0;
            o_p_rd_l <= '0;
            o_p_rd_r <= '0;
        end else begin
            o_out_valid <= r_state == S_EXEC && w_oval;
            o_c_start <= r_state == S_EXEC && w_fwd;
            // Write-first: a node written this cycle is read back with its new value.
            o_p_rd_l <= (LEVEL == 1) ? '0 : (w_we && w_widx == w_pl) ? w_wdata : r_mem[w_pl];
            o_p_rd_r <= (LEVEL == 1) ? '0 : (w_we && w_widx == w_pr) ? w_wdata : r_mem[w_pr];
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + AW'(1);
                    if (r_ptr == MASK) begin
                        r_state <= S_IDLE;
                        o_ready <= 1'b1;
                        o_done <= D_DONE;
                    end
                end
                S_IDLE: if (i_start && w_acc) begin
                    r_state <= S_EXEC;
                    r_op <= i_op;
                    r_addr <= i_addr;
                    r_in <= i_in_pri;
                    o_ready <= 1'b0;
                    o_done <= D_WAIT;
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                    o_done <= w_fwd ? D_NEXT : D_DONE;
                    o_out_pri <= w_opri;
                    o_c_op <= w_cop;
                    o_c_addr <= (LEVEL'(r_addr) << 1) | LEVEL'(w_side);
                    o_c_pri <= w_cpri;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_pheap_level.sv
// tb_pheap_level: level 2 of a 3-level heap against a behavioural leaf child and a per-subtree multiset model.
module tb_pheap_level;
    localparam logic [1:0] ENQ = 2'd1, DEQ = 2'd2;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, addr = 1'b0, p_raddr = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] in_pri = '0;
    logic        ready, out_valid, c_raddr, c_start;
    logic [1:0]  done, c_op, c_addr;
    logic [31:0] out_pri, c_pri;
    logic [35:0] c_rd_l, c_rd_r, p_rd_l, p_rd_r;
    int total = 0, bad = 0;

    logic [31:0] ch_pri [4];
    logic [2:0]  ch_cap [4];
    logic        ch_act [4];
    logic        ca;

    pheap_level #(.LEVELS(3), .LEVEL(2), .PW(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_op(op), .i_addr(addr), .i_in_pri(in_pri),
        .o_ready(ready), .o_done(done), .o_out_valid(out_valid), .o_out_pri(out_pri),
        .o_c_raddr(c_raddr), .i_c_rd_l(c_rd_l), .i_c_rd_r(c_rd_r), .o_c_start(c_start),
        .o_c_op(c_op), .o_c_addr(c_addr), .o_c_pri(c_pri), .i_p_raddr(p_raddr),
        .o_p_rd_l(p_rd_l), .o_p_rd_r(p_rd_r)
    );

    always #5 clk = ~clk;

    // Behavioural leaf level: four single-node subtrees, capacity 1 when empty.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                ch_pri[k] <= '0;
                ch_cap[k] <= 3'd1;
                ch_act[k] <= 1'b0;
            end
            ca <= 1'b0;
        end else begin
            ca <= c_raddr;
            if (c_start && c_op == ENQ) begin
                if (!ch_act[c_addr]) begin
                    ch_pri[c_addr] <= c_pri;
                    ch_cap[c_addr] <= 3'd0;
                    ch_act[c_addr] <= 1'b1;
                end else if (c_pri > ch_pri[c_addr]) ch_pri[c_addr] <= c_pri;
            end else if (c_start && c_op == DEQ) begin
                ch_pri[c_addr] <= '0;
                ch_cap[c_addr] <= 3'd1;
                ch_act[c_addr] <= 1'b0;
            end
        end
    end
    assign c_rd_l = {ch_pri[{ca, 1'b0}], ch_cap[{ca, 1'b0}], ch_act[{ca, 1'b0}]};
    assign c_rd_r = {ch_pri[{ca, 1'b1}], ch_cap[{ca, 1'b1}], ch_act[{ca, 1'b1}]};

    function automatic logic [35:0] ent(input logic [31:0] p, input logic [2:0] c, input logic a);
        return {p, c, a};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout ready=%b required=1", ready);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic a, input logic [31:0] p);
        wait_ready();
        start = 1'b1;
        op = o;
        addr = a;
        in_pri = p;
        @(negedge clk);
        start = 1'b0;
        op = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
        total++; if (done !== 2'd1) begin bad++; $display("FAIL rst_done got=%0d exp=1", done); end
        total++; if (c_start !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b exp=00", c_start, out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL init_ready_low got=%b exp=0", ready); end
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL init_ready_high got=%b exp=1", ready); end
        total++; if (done !== 2'd0) begin bad++; $display("FAIL init_done got=%0d exp=0", done); end
        total++; if (p_rd_l !== ent(0, 3, 0)) begin bad++; $display("FAIL init_node0 got=%h exp=%h", p_rd_l, ent(0, 3, 0)); end
        total++; if (p_rd_r !== ent(0, 3, 0)) begin bad++; $display("FAIL init_node1 got=%h exp=%h", p_rd_r, ent(0, 3, 0)); end
    endtask

    task automatic test_enq();
        p_raddr = 1'b0;
        do_op(ENQ, 1'b0, 32'h10);
        total++; if (done !== 2'd0 || c_start !== 1'b0) begin bad++; $display("FAIL enq1_done got=%0d/%b exp=0/0", done, c_start); end
        total++; if (p_rd_l !== ent(32'h10, 2, 1)) begin bad++; $display("FAIL enq1_node got=%h exp=%h", p_rd_l, ent(32'h10, 2, 1)); end
        do_op(ENQ, 1'b0, 32'h30);
        total++; if (done !== 2'd2 || c_start !== 1'b1) begin bad++; $display("FAIL enq2_done got=%0d/%b exp=2/1", done, c_start); end
        total++; if (out_pri !== 32'h10 || c_pri !== 32'h10) begin bad++; $display("FAIL enq2_push got=%h/%h exp=10/10", out_pri, c_pri); end
        total++; if (c_addr !== 2'd0 || c_op !== ENQ) begin bad++; $display("FAIL enq2_child got=%0d/%0d exp=0/1", c_addr, c_op); end
        total++; if (p_rd_l !== ent(32'h30, 1, 1)) begin bad++; $display("FAIL enq2_node got=%h exp=%h", p_rd_l, ent(32'h30, 1, 1)); end
    endtask

    task automatic test_deq();
        do_op(ENQ, 1'b0, 32'h20);
        total++; if (c_addr !== 2'd1 || out_pri !== 32'h20) begin bad++; $display("FAIL enq3_side got=%0d/%h exp=1/20", c_addr, out_pri); end
        do_op(DEQ, 1'b0, 32'h0);
        total++; if (out_valid !== 1'b1 || out_pri !== 32'h30) begin bad++; $display("FAIL deq_out got=%b/%h exp=1/30", out_valid, out_pri); end
        total++; if (p_rd_l !== ent(32'h20, 1, 1)) begin bad++; $display("FAIL deq_node got=%h exp=%h", p_rd_l, ent(32'h20, 1, 1)); end
        total++; if (c_start !== 1'b1 || c_op !== DEQ || c_addr !== 2'd1 || done !== 2'd2) begin bad++; $display("FAIL deq_child got=%b/%0d/%0d/%0d exp=1/2/1/2", c_start, c_op, c_addr, done); end
    endtask

    task automatic test_ignore();
        wait_ready();
        start = 1'b1;
        op = 2'd0;
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL nop_ready got=%b exp=1", ready); end
        op = 2'd3;
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL op3_ready got=%b exp=1", ready); end
        op = ENQ;
        addr = 1'b1;
        in_pri = 32'h55;
        @(negedge clk);
        total++; if (ready !== 1'b0 || done !== 2'd1) begin bad++; $display("FAIL exec_state got=%b/%0d exp=0/1", ready, done); end
        op = DEQ;
        addr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++; if (ready !== 1'b1 || done !== 2'd0) begin bad++; $display("FAIL busy_done got=%b/%0d exp=1/0", ready, done); end
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL busy_ignored got=%b exp=1", ready); end
        total++; if (p_rd_l !== ent(32'h20, 1, 1)) begin bad++; $display("FAIL busy_node0 got=%h exp=%h", p_rd_l, ent(32'h20, 1, 1)); end
        total++; if (p_rd_r !== ent(32'h55, 2, 1)) begin bad++; $display("FAIL busy_node1 got=%h exp=%h", p_rd_r, ent(32'h55, 2, 1)); end
    endtask

    task automatic test_reset_mid();
        do_op(ENQ, 1'b0, 32'h40);
        total++; if (c_start !== 1'b1) begin bad++; $display("FAIL mid_pulse got=%b exp=1", c_start); end
        rst_n = 1'b0;
        #1;
        total++; if (c_start !== 1'b0 || ready !== 1'b0 || done !== 2'd1) begin bad++; $display("FAIL mid_reset got=%b/%b/%0d exp=0/0/1", c_start, ready, done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_reinit_ready got=%b exp=1", ready); end
        total++; if (p_rd_l !== ent(0, 3, 0)) begin bad++; $display("FAIL mid_reinit_node got=%h exp=%h", p_rd_l, ent(0, 3, 0)); end
    endtask

    // Each node plus its two leaves is a 3-entry max priority queue.
    task automatic test_random();
        int cnt[2];
        int vals[2][3];
        int n, p, mx, mi;
        logic a, ev;
        logic [1:0] o, ed;
        logic [31:0] ep;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        cnt = '{0, 0};
        for (int i = 0; i < 250; i++) begin
            a = 1'($urandom_range(0, 1));
            n = cnt[a];
            p = int'($urandom_range(0, 15));
            o = (n == 3) ? DEQ : (n == 0) ? (($urandom_range(0, 4) == 0) ? DEQ : ENQ) : ($urandom_range(0, 1) != 0 ? ENQ : DEQ);
            mx = 0;
            mi = 0;
            for (int k = 0; k < n; k++) if (vals[a][k] > mx) begin mx = vals[a][k]; mi = k; end
            do_op(o, a, 32'(p));
            ev = n > 0;
            if (o == ENQ) begin
                ep = (n == 0) ? 32'd0 : 32'((p < mx) ? p : mx);
                ed = (n > 0) ? 2'd2 : 2'd0;
                vals[a][n] = p;
                cnt[a] = n + 1;
            end else begin
                ep = 32'(mx);
                ed = (n > 1) ? 2'd2 : 2'd0;
                if (n > 0) begin
                    vals[a][mi] = vals[a][n-1];
                    cnt[a] = n - 1;
                end
            end
            total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_valid i=%0d op=%0d got=%b exp=%b", i, o, out_valid, ev); end
            total++; if (done !== ed) begin bad++; $display("FAIL rnd_done i=%0d op=%0d got=%0d exp=%0d", i, o, done, ed); end
            total++; if (c_start !== (ed == 2'd2)) begin bad++; $display("FAIL rnd_cstart i=%0d got=%b exp=%b", i, c_start, ed == 2'd2); end
            if (o == ENQ || ev) begin
                total++; if (out_pri !== ep) begin bad++; $display("FAIL rnd_pri i=%0d op=%0d got=%0h exp=%0h", i, o, out_pri, ep); end
            end
            if (ed == 2'd2) begin
                total++; if (c_op !== o) begin bad++; $display("FAIL rnd_cop i=%0d got=%0d exp=%0d", i, c_op, o); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_enq();
        test_deq();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
